// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code sequence decoder.
package gray_pkg;
    localparam int GRAY_WIDTH = 3;
    localparam logic [3:0] WRAP_CNT_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;
endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary conversion.
module gray2bin
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Bin
);
    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign Bin[i] = ^Gray[WIDTH-1:i];
    end
endmodule

// File: rtl/gray_decoder.sv
// Tracks a Gray-coded counter: decodes each sample, checks single-step
// progression, counts max-to-0 wraps and flags sequence violations.
//
// state | meaning
// IDLE  | no reference value; next sample is accepted unchecked
// TRACK | Bin is the reference; samples must hold or step by +1
// ERROR | sequence violated; samples ignored until Clear or Reset
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Gray,
    input  logic             Clear,
    output logic [WIDTH-1:0] Bin,
    output logic             BinValid,
    output logic             Wrap,
    output logic [3:0]       WrapCount,
    output logic             Error
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] bin_inc;
    logic [WIDTH-1:0] bin_nxt;
    logic             binvalid_nxt;
    logic             wrap_nxt;
    logic [3:0]       wrapcount_nxt;
    logic             error_nxt;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .Gray (Gray),
        .Bin  (dec)
    );

    assign bin_inc = Bin + ONE;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            Bin       <= '0;
            BinValid  <= 1'b0;
            Wrap      <= 1'b0;
            WrapCount <= '0;
            Error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            Bin       <= bin_nxt;
            BinValid  <= binvalid_nxt;
            Wrap      <= wrap_nxt;
            WrapCount <= wrapcount_nxt;
            Error     <= error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bin_nxt       = Bin;
        binvalid_nxt  = 1'b0;
        wrap_nxt      = 1'b0;
        wrapcount_nxt = WrapCount;
        error_nxt     = Error;

        // Clear beats a coincident sample; Bin is deliberately kept.
        if (Clear) begin
            state_nxt     = IDLE;
            wrapcount_nxt = '0;
            error_nxt     = 1'b0;
        end else if (Valid) begin
            case (state)
                IDLE: begin
                    bin_nxt      = dec;
                    binvalid_nxt = 1'b1;
                    state_nxt    = TRACK;
                end
                TRACK: begin
                    if (dec == Bin) begin
                        binvalid_nxt = 1'b1;
                    end else if (dec == bin_inc) begin
                        bin_nxt      = dec;
                        binvalid_nxt = 1'b1;
                        if (&Bin) begin
                            wrap_nxt = 1'b1;
                            if (WrapCount != WRAP_CNT_MAX)
                                wrapcount_nxt = WrapCount + 4'd1;
                        end
                    end else begin
                        error_nxt = 1'b1;
                        state_nxt = ERROR;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder (WIDTH=3): directed vectors, a behavioural model
// compared every cycle, and literal expectations at key points.
module tb_gray_decoder;
    logic       Clk;
    logic       Reset;
    logic       Valid;
    logic [2:0] Gray;
    logic       Clear;
    logic [2:0] Bin;
    logic       BinValid;
    logic       Wrap;
    logic [3:0] WrapCount;
    logic       Error;

    int n_assert = 0;
    int n_fail   = 0;

    gray_decoder #(.WIDTH(3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Valid     (Valid),
        .Gray      (Gray),
        .Clear     (Clear),
        .Bin       (Bin),
        .BinValid  (BinValid),
        .Wrap      (Wrap),
        .WrapCount (WrapCount),
        .Error     (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural model: integers and flags, not a state machine copy.
    int m_bin, m_bv, m_wrap, m_wc, m_err;
    bit have_prev, locked, chk_en;

    function automatic int gray_to_int(input int g);
        int d = 0;
        for (int s = 0; s < 3; s++) d = d ^ (g >> s);
        return d & 7;
    endfunction

    function automatic logic [2:0] enc(input int n);
        int g = n ^ (n >> 1);
        return g[2:0];
    endfunction

    always @(posedge Clk) begin
        int d;
        if (Reset) begin
            m_bin = 0; m_bv = 0; m_wrap = 0; m_wc = 0; m_err = 0;
            have_prev = 0; locked = 0; chk_en = 1;
        end else begin
            m_bv = 0; m_wrap = 0;
            if (Clear) begin
                have_prev = 0; locked = 0; m_err = 0; m_wc = 0;
            end else if (Valid && !locked) begin
                d = gray_to_int(int'(Gray));
                if (!have_prev) begin
                    m_bin = d; m_bv = 1; have_prev = 1;
                end else if (d == m_bin) begin
                    m_bv = 1;
                end else if (d == (m_bin + 1) % 8) begin
                    if (d == 0) begin
                        m_wrap = 1;
                        m_wc = (m_wc < 15) ? m_wc + 1 : 15;
                    end
                    m_bin = d; m_bv = 1;
                end else begin
                    m_err = 1; locked = 1;
                end
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            cmp("model Bin", int'(Bin), m_bin);
            cmp("model BinValid", int'(BinValid), m_bv);
            cmp("model Wrap", int'(Wrap), m_wrap);
            cmp("model WrapCount", int'(WrapCount), m_wc);
            cmp("model Error", int'(Error), m_err);
        end
    end

    // Drives at a falling edge and returns at the next one, when the
    // outputs reflect this cycle's inputs.
    task automatic cyc(input logic r, input logic c, input logic v, input logic [2:0] g);
        Reset = r; Clear = c; Valid = v; Gray = g;
        @(negedge Clk);
    endtask

    task automatic samp(input logic [2:0] g);
        cyc(1'b0, 1'b0, 1'b1, g);
    endtask

    initial begin
        Reset = 1'b1; Clear = 1'b0; Valid = 1'b0; Gray = '0;
        @(negedge Clk);
        cyc(1'b1, 1'b0, 1'b0, 3'b000);
        cmp("reset Bin", int'(Bin), 0);
        cmp("reset BinValid", int'(BinValid), 0);
        cmp("reset WrapCount", int'(WrapCount), 0);
        cmp("reset Error", int'(Error), 0);

        // Basic decode from IDLE
        samp(3'b000); cmp("seq Bin0", int'(Bin), 0); cmp("seq BV0", int'(BinValid), 1);
        samp(3'b001); cmp("seq Bin1", int'(Bin), 1);
        samp(3'b011); cmp("seq Bin2", int'(Bin), 2);
        samp(3'b010); cmp("seq Bin3", int'(Bin), 3); cmp("seq Err", int'(Error), 0);
        cyc(1'b0, 1'b0, 1'b0, 3'b111);
        cmp("idle BV", int'(BinValid), 0); cmp("idle Bin", int'(Bin), 3);

        // Rest of the cycle through the wrap
        samp(3'b110); samp(3'b111); samp(3'b101);
        samp(3'b100); cmp("prewrap Bin", int'(Bin), 7); cmp("prewrap Wrap", int'(Wrap), 0);
        samp(3'b000); cmp("wrap pulse", int'(Wrap), 1); cmp("wrap Bin", int'(Bin), 0);
        cmp("wrap count", int'(WrapCount), 1);
        samp(3'b000); cmp("wrap one cycle", int'(Wrap), 0);

        // Hold then backward step
        cyc(1'b0, 1'b1, 1'b0, 3'b000);
        samp(3'b010); cmp("hold Bin a", int'(Bin), 3);
        samp(3'b010); cmp("hold Bin b", int'(Bin), 3); cmp("hold BV", int'(BinValid), 1);
        samp(3'b011); cmp("back Err", int'(Error), 1); cmp("back Bin", int'(Bin), 3);

        // Skip, ignore while in error, clear, restart from IDLE
        cyc(1'b0, 1'b1, 1'b0, 3'b000); cmp("clear Err", int'(Error), 0);
        samp(3'b011); cmp("skip pre Bin", int'(Bin), 2);
        samp(3'b110); cmp("skip Err", int'(Error), 1); cmp("skip BV", int'(BinValid), 0);
        cmp("skip Bin", int'(Bin), 2);
        samp(3'b111); cmp("ignored Bin", int'(Bin), 2); cmp("ignored BV", int'(BinValid), 0);
        cyc(1'b0, 1'b1, 1'b0, 3'b000); cmp("clear2 Err", int'(Error), 0);
        cmp("clear2 Bin kept", int'(Bin), 2);
        samp(3'b101); cmp("restart Bin", int'(Bin), 6); cmp("restart Err", int'(Error), 0);

        // WrapCount saturation
        cyc(1'b0, 1'b1, 1'b0, 3'b000);
        samp(3'b000);
        for (int k = 1; k <= 17; k++) begin
            for (int n = 1; n < 8; n++) samp(enc(n));
            samp(3'b000);
            if (k == 15) cmp("sat at 15", int'(WrapCount), 15);
            if (k >= 16) cmp("sat wrap pulse", int'(Wrap), 1);
        end
        cmp("sat stays 15", int'(WrapCount), 15);

        // Reset mid-sequence with Valid and Clear high
        samp(3'b001);
        cyc(1'b1, 1'b1, 1'b1, 3'b011);
        cmp("midreset Bin", int'(Bin), 0); cmp("midreset WC", int'(WrapCount), 0);
        cmp("midreset BV", int'(BinValid), 0);

        // Clear beats Valid; state returns to IDLE
        samp(3'b011); cmp("cv pre Bin", int'(Bin), 2);
        cyc(1'b0, 1'b1, 1'b1, 3'b010);
        cmp("cv BV", int'(BinValid), 0); cmp("cv Bin", int'(Bin), 2);
        samp(3'b110); cmp("cv idle Bin", int'(Bin), 4); cmp("cv idle Err", int'(Error), 0);

        // Reset while in ERROR
        samp(3'b000); cmp("err pre", int'(Error), 1);
        cyc(1'b1, 1'b0, 1'b1, 3'b001); cmp("err reset", int'(Error), 0);
        samp(3'b111); cmp("post reset Bin", int'(Bin), 5);
        cyc(1'b0, 1'b0, 1'b0, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/gray_decoder.md
GRAY_DECODER -- requirements
Module: gray_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: code width in bits, minimum 2.
REQ-002 The block SHALL have input Clk, 1 bit: clock; all state changes on the rising edge.
REQ-003 The block SHALL have input Reset, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input Valid, 1 bit: Gray holds a sample this cycle.
REQ-005 The block SHALL have input Gray, WIDTH bits: Gray-coded sample.
REQ-006 The block SHALL have input Clear, 1 bit: drop error and tracking state, return to IDLE.
REQ-007 The block SHALL have output Bin, WIDTH bits, registered: binary value of the last accepted sample.
REQ-008 The block SHALL have output BinValid, 1 bit, registered: Bin was updated or confirmed by the previous cycle's sample.
REQ-009 The block SHALL have output Wrap, 1 bit, registered: one-cycle pulse on a max-to-0 step.
REQ-010 The block SHALL have output WrapCount, 4 bits, registered: saturating count of wraps.
REQ-011 The block SHALL have output Error, 1 bit, registered: sticky sequence-violation flag.

Function
REQ-012 The block SHALL decode d = binary(Gray) with d[W-1] = g[W-1] and d[i] = d[i+1] XOR g[i].
REQ-013 All outputs SHALL reflect a Valid sample exactly one clock after that sample (1-cycle latency).
REQ-014 The FSM SHALL have three states: IDLE, TRACK and ERROR; the previous value p is the current Bin.
REQ-015 In IDLE, on Valid: Bin = d, BinValid = 1, go to TRACK; no wrap or error check.
REQ-016 In TRACK, on Valid with d == p: hold case; BinValid = 1, Wrap = 0, Bin unchanged.
REQ-017 In TRACK, on Valid with d == (p+1) mod 2^WIDTH: Bin = d, BinValid = 1.
REQ-018 If that step is p == 2^WIDTH-1 to d == 0: Wrap = 1 for one cycle and WrapCount += 1, saturating at 15.
REQ-019 In TRACK, any other d (skip, backward step, multi-bit change): Error = 1, BinValid = 0, Bin holds p, go to ERROR.
REQ-020 In ERROR: Valid is ignored, BinValid = 0, Wrap = 0, Error stays 1.
REQ-021 Clear in any state SHALL, on the next edge, give: state IDLE, Error 0, WrapCount 0, BinValid 0, Wrap 0, Bin retained.
REQ-022 Clear asserted in the same cycle as Valid SHALL win; that sample is discarded.
REQ-023 Valid low (and no Clear): BinValid = 0, Wrap = 0, state and Bin hold.
REQ-024 The WrapCount saturated at 15 SHALL stay at 15 on further wraps; Wrap still pulses.

Reset
REQ-025 On Reset: Bin 0, BinValid 0, Wrap 0, WrapCount 0, Error 0, state IDLE.
REQ-026 Reset SHALL take priority over Clear and Valid, including mid-sequence and while in ERROR.
REQ-027 There SHALL be no initial-block reliance; reset is the only initialisation.

Structure
REQ-028 Package gray_pkg SHALL hold the WIDTH default, the FSM state enum (IDLE/TRACK/ERROR) and WRAP_CNT_MAX = 15.
REQ-029 Combinational sub-module gray2bin (parameter WIDTH, in Gray, out Bin) SHALL implement REQ-012.
REQ-030 gray2bin SHALL be instantiated once, with all registers in gray_decoder.

Verification (WIDTH=3)
REQ-031 Reset, then Valid with 000,001,011,010 on consecutive cycles -> one cycle later each, Bin = 0,1,2,3, BinValid 1, Error 0.
REQ-032 Full sequence 000,001,011,010,110,111,101,100,000 -> Wrap = 1 only in the cycle Bin becomes 0; WrapCount = 1.
REQ-033 Sample 011 then 110 (2 to 4) -> Error 1, BinValid 0, Bin = 2; a later Valid 111 is ignored; Clear -> Error 0 next cycle; next sample 101 gives Bin = 6 with no error.
REQ-034 Samples 010,010,011 -> Bin = 3,3 with BinValid 1 and no error; then 011 gives Error 1 (3 to 2, backward).
REQ-035 Drive 17 full cycles -> WrapCount = 15 after the 15th wrap and stays 15; Wrap still pulses on wraps 16 and 17.
REQ-036 Reset asserted mid-sequence with Valid high -> all outputs at reset values next cycle; Clear and Valid together -> sample discarded, state IDLE.
